adc_scan_scheduler: RTL
=======================

// Module: adc_scan_scheduler
// PURPOSE
//   Round-robin scanner for the four iceFUN ADC channels over the shared 250k-baud UART link.
//   Issues a command byte 0xA1..0xA4 per enabled channel and collects the 2-byte reply (low byte, then bits [9:8]).
//   Stores one 10-bit result per channel and pulses a per-sample strobe.
//   Sits between user logic and the byte-level UART tx/rx instances, which it owns exclusively.
// PARAMETERS
//   CHANNELS       4      number of ADC channels scanned; 1..4
//   CMD_BASE       8'hA1  command byte for channel 0; channel n sends CMD_BASE+n
//   TIMEOUT_TICKS  12000  clocks allowed per phase (send, rx low, rx high); 1 ms at 12 MHz
// PORTS
//   clock12MHz    in   1   system clock; all logic on posedge
//   resetN        in   1   synchronous reset, active low
//   run           in   1   1 = keep scanning; 0 = finish the current channel, then idle
//   enableMask    in   4   per-channel enable; bit n = channel n; only bits [CHANNELS-1:0] are used
//   sendRequest   out  1   to UART tx; held high until sendComplete
//   sendData      out  8   to UART tx; command byte, stable while sendRequest=1
//   sendComplete  in   1   from UART tx; frame sent
//   readyForRx    out  1   to UART rx; armed for one byte
//   rxData        in   8   from UART rx; valid while rxComplete=1
//   rxComplete    in   1   from UART rx; byte received; held until readyForRx drops
//   results       out  40  {ch3,ch2,ch1,ch0}, 10 bits per channel
//   sampleValid   out  1   1-cycle pulse when one results slot has been updated
//   sampleChannel out  2   channel index of the last update or timeout; held between events
//   timeoutErr    out  1   1-cycle pulse when a phase times out (only with ADC_TIMEOUT_EN)
//   busy          out  1   1 in any state other than IDLE
// BEHAVIOUR
//   Reset (resetN=0 at an edge): state=IDLE, sendRequest=0, readyForRx=0, sendData=0, results=0,
//     sampleValid=0, sampleChannel=0, timeoutErr=0, busy=0, last-channel pointer=CHANNELS-1.
//     A reset mid-transaction drops sendRequest and readyForRx on that same edge.
//   States: IDLE -> PICK -> SEND -> RX_LO -> GAP -> RX_HI -> STORE -> PICK | IDLE.
//   IDLE: if run=1 and (enableMask & used bits) != 0, go to PICK; otherwise stay in IDLE.
//   PICK: samples enableMask once.
//     - Chooses the first enabled channel after the last-channel pointer, wrapping at CHANNELS-1 -> 0.
//     - With a single enabled channel, that channel is rescanned.
//     - Mask now 0: return to IDLE.
//     - Otherwise load sendData=CMD_BASE+ch, set sendRequest=1, go to SEND.
//   SEND: on sendComplete=1, set sendRequest=0 and readyForRx=1, go to RX_LO.
//   RX_LO: on rxComplete=1, latch rxData into lo[7:0], set readyForRx=0, go to GAP.
//   GAP: wait for rxComplete=0, then set readyForRx=1 and go to RX_HI.
//     This blocks a stale completion from being taken as the second byte.
//   RX_HI: on rxComplete=1, latch rxData[1:0] as hi, set readyForRx=0, go to STORE.
//     rxData[7:2] is ignored.
//   STORE: results[10*ch +: 10] <= {hi, lo}, applied in one write; no partial update is ever visible.
//     Same edge: sampleValid=1, sampleChannel=ch, pointer=ch.
//     Next state: PICK if run=1, else IDLE.
//   Latency, ideal UART, from PICK: sendRequest rises 1 cycle after entering PICK.
//     sampleValid fires 1 cycle after the RX_HI completion edge.
//     There are no idle cycles between channels when run=1.
//   run=0 mid-transaction does not abort; the current channel completes and is stored.
//   enableMask changes outside PICK have no effect until the next PICK.
//   Simultaneous sampleValid and timeoutErr is impossible (they come from different states).
// CONFIGURATION
//   ADC_TIMEOUT_EN defined:
//     - A 14-bit phase counter clears on entry to SEND, RX_LO and RX_HI.
//     - When it reaches TIMEOUT_TICKS-1 in such a phase, drop sendRequest and readyForRx.
//     - Same edge: pulse timeoutErr, set sampleChannel=ch, pointer=ch; that channel's result is unchanged.
//     - Then go to PICK (run=1) or IDLE (run=0).
//   ADC_TIMEOUT_EN undefined: no counter; each phase waits indefinitely.
//     timeoutErr is tied to 0.
// TESTING
//   1 Reset, mask=4'b1111, run=1, model replies lo=0x34, hi=0x02 -> commands A1,A2,A3,A4,A1 in order; results ch0=0x234.
//   2 mask=4'b0100, run=1, reply 0xFF, 0xFF -> only A3 is sent, repeatedly; ch2=0x3FF; other slots stay 0.
//   3 run dropped during RX_LO of ch1 -> ch1 is stored and sampleValid pulses; busy falls next cycle; no further sendRequest.
//   4 rxComplete held high 5 cycles after byte 1 -> readyForRx stays 0 until it falls; the second byte is not the first byte reused.
//   5 ADC_TIMEOUT_EN, TIMEOUT_TICKS=100, no reply on ch0 -> timeoutErr pulses 100 cycles after RX_LO entry; ch0 unchanged; next command A2.
//   6 resetN=0 for one cycle during SEND -> sendRequest=0 that edge; results=0; the next scan begins with A1.

Source files
------------

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: round-robin ADC scanner over a shared UART link; define ADC_TIMEOUT_EN for per-phase timeouts
module adc_scan_scheduler #(
  parameter int CHANNELS = 4,
  parameter logic [7:0] CMD_BASE = 8'hA1,
  parameter int TIMEOUT_TICKS = 12000
) (
  input  logic        clock12MHz,
  input  logic        resetN,
  input  logic        run,
  input  logic [3:0]  enableMask,
  output logic        sendRequest,
  output logic [7:0]  sendData,
  input  logic        sendComplete,
  output logic        readyForRx,
  input  logic [7:0]  rxData,
  input  logic        rxComplete,
  output logic [39:0] results,
  output logic        sampleValid,
  output logic [1:0]  sampleChannel,
  output logic        timeoutErr,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, PICK, SEND, RX_LO, GAP, RX_HI, STORE} state_t;
  localparam logic [3:0] USED = 4'((1 << CHANNELS) - 1);
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, ch_q, ch_d, samp_ch_q, samp_ch_d, next_ch, idx;
  logic [7:0] lo_q, lo_d, send_data_q, send_data_d;
  logic [1:0] hi_q, hi_d;
  logic [39:0] results_q, results_d;
  logic send_req_q, send_req_d, rdy_q, rdy_d, valid_q, valid_d, terr_q, terr_d;
  logic [3:0] mask;
  logic found, tmo;
  assign mask = enableMask & USED;
  // descending scan so the nearest channel after the pointer wins
  always_comb begin
    next_ch = ptr_q;
    found = 1'b0;
    idx = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = 2'((int'(ptr_q) + i) % CHANNELS);
      if (mask[idx]) begin
        next_ch = idx;
        found = 1'b1;
      end
    end
  end
`ifdef ADC_TIMEOUT_EN
  logic [13:0] cnt_q, cnt_d;
  assign cnt_d = (state_d != state_q) ? '0 : cnt_q + 14'd1;
  assign tmo = (state_q == SEND || state_q == RX_LO || state_q == RX_HI) && cnt_q == 14'(TIMEOUT_TICKS - 1);
  always_ff @(posedge clock12MHz) cnt_q <= !resetN ? '0 : cnt_d;
`else
  assign tmo = TIMEOUT_TICKS < 0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    ch_d = ch_q;
    samp_ch_d = samp_ch_q;
    lo_d = lo_q;
    hi_d = hi_q;
    send_data_d = send_data_q;
    results_d = results_q;
    send_req_d = send_req_q;
    rdy_d = rdy_q;
    valid_d = 1'b0;
    terr_d = 1'b0;
    case (state_q)
      IDLE: state_d = (run && |mask) ? PICK : IDLE;
      PICK: begin
        state_d = found ? SEND : IDLE;
        ch_d = found ? next_ch : ch_q;
        send_data_d = found ? CMD_BASE + 8'(next_ch) : send_data_q;
        send_req_d = found;
      end
      SEND: if (sendComplete) begin
        send_req_d = 1'b0;
        rdy_d = 1'b1;
        state_d = RX_LO;
      end
      RX_LO: if (rxComplete) begin
        lo_d = rxData;
        rdy_d = 1'b0;
        state_d = GAP;
      end
      GAP: if (!rxComplete) begin
        rdy_d = 1'b1;
        state_d = RX_HI;
      end
      RX_HI: if (rxComplete) begin
        hi_d = rxData[1:0];
        rdy_d = 1'b0;
        state_d = STORE;
      end
      STORE: begin
        results_d[10*int'(ch_q) +: 10] = {hi_q, lo_q};
        valid_d = 1'b1;
        samp_ch_d = ch_q;
        ptr_d = ch_q;
        state_d = run ? PICK : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      send_req_d = 1'b0;
      rdy_d = 1'b0;
      terr_d = 1'b1;
      samp_ch_d = ch_q;
      ptr_d = ch_q;
      state_d = run ? PICK : IDLE;
    end
  end
  always_ff @(posedge clock12MHz) begin
    if (!resetN) begin
      state_q <= IDLE;
      ptr_q <= 2'(CHANNELS - 1);
      ch_q <= '0;
      samp_ch_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      send_data_q <= '0;
      results_q <= '0;
      send_req_q <= 1'b0;
      rdy_q <= 1'b0;
      valid_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      ch_q <= ch_d;
      samp_ch_q <= samp_ch_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      send_data_q <= send_data_d;
      results_q <= results_d;
      send_req_q <= send_req_d;
      rdy_q <= rdy_d;
      valid_q <= valid_d;
      terr_q <= terr_d;
    end
  end
  assign sendRequest = send_req_q;
  assign sendData = send_data_q;
  assign readyForRx = rdy_q;
  assign results = results_q;
  assign sampleValid = valid_q;
  assign sampleChannel = samp_ch_q;
  assign timeoutErr = terr_q;
  assign busy = state_q != IDLE;
endmodule
